// File: rtl/pio_in_pkg.sv
// Shared definitions for the pio_in parallel input port: register map and
// default debounce configuration.
package pio_in_pkg;

  typedef enum logic [1:0] {
    PIO_IN_LEVEL   = 2'd0,
    PIO_IN_CAPTURE = 2'd1,
    PIO_IN_MASK    = 2'd2,
    PIO_IN_RAW     = 2'd3
  } pio_in_addr_e;

  localparam int PIO_IN_DB_COUNT_DEFAULT = 50000;
  localparam int PIO_IN_CNT_W_DEFAULT    = 16;
  localparam int PIO_IN_BUS_W            = 32;

endpackage

// File: rtl/pio_in_debounce.sv
// Single-bit debounce filter: the level follows din only after din has
// differed from it for DB_COUNT consecutive cycles.
module pio_in_debounce #(
  parameter int DB_COUNT = 50000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic level_next
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_COUNT - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Any sample agreeing with the current level restarts the stability count.
  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    if (din == level) begin
      cnt_next = '0;
    end else if (cnt == CntLast) begin
      level_next = din;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      level <= level_next;
    end
  end

endmodule

// File: rtl/pio_in.sv
// Parallel input port with synchronizer, sticky rising-edge capture and
// maskable irq. Define PIO_IN_DEBOUNCE_EN to add per-bit debounce filters.
module pio_in
  import pio_in_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DB_COUNT = PIO_IN_DB_COUNT_DEFAULT,
  parameter int CNT_W    = PIO_IN_CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    EN,
  input  logic                    WE,
  input  logic [1:0]              ADDR,
  input  logic [PIO_IN_BUS_W-1:0] PData_in,
  input  logic [WIDTH-1:0]        PIN,
  output logic [PIO_IN_BUS_W-1:0] PData_out,
  output logic                    irq
);

  logic [WIDTH-1:0]        sync1;
  logic [WIDTH-1:0]        sync2;
  logic [WIDTH-1:0]        level;
  logic [WIDTH-1:0]        level_next;
  logic [WIDTH-1:0]        capture;
  logic [WIDTH-1:0]        mask;
  logic [WIDTH-1:0]        rise;
  logic [WIDTH-1:0]        clr;
  logic [WIDTH-1:0]        rd_sel;
  logic [PIO_IN_BUS_W-1:0] rd_data;
  logic                    wr;
  logic                    rd;

  // Upper bus bits are unused for narrow ports, and the debounce parameters
  // only matter in filtered builds.
  logic [PIO_IN_BUS_W+63:0] unused_bits;
  assign unused_bits = {PData_in, 32'(DB_COUNT), 32'(CNT_W)};

  assign wr = EN && WE;
  assign rd = EN && !WE;

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_in_debounce #(
      .DB_COUNT(DB_COUNT),
      .CNT_W   (CNT_W)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .din       (sync2[i]),
      .level     (level[i]),
      .level_next(level_next[i])
    );
  end
`else
  assign level_next = sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      level <= level_next;
    end
  end
`endif

  assign rise = level_next & ~level;
  assign clr  = (wr && ADDR == PIO_IN_CAPTURE) ? PData_in[WIDTH-1:0] : '0;
  assign irq  = |(capture & mask);

  always_comb begin
    rd_sel = '0;
    case (ADDR)
      PIO_IN_LEVEL:   rd_sel = level;
      PIO_IN_CAPTURE: rd_sel = capture;
      PIO_IN_MASK:    rd_sel = mask;
      PIO_IN_RAW:     rd_sel = sync2;
      default:        rd_sel = '0;
    endcase
    rd_data = PIO_IN_BUS_W'(rd_sel);
  end

  // A rise in the same cycle as a write-1-to-clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      capture   <= '0;
      mask      <= '0;
      PData_out <= '0;
    end else begin
      sync1   <= PIN;
      sync2   <= sync1;
      capture <= (capture & ~clr) | rise;
      if (wr && ADDR == PIO_IN_MASK) begin
        mask <= PData_in[WIDTH-1:0];
      end
      if (rd) begin
        PData_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_pio_in.sv
// Self-checking bench for pio_in; expectations come from a window-based
// model of the input history (works with or without PIO_IN_DEBOUNCE_EN).
module tb_pio_in;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int CW = 16;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int LAT   = DB + 2;
`else
  localparam bit DB_ON = 1'b0;
  localparam int LAT   = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic        WE;
  logic [1:0]  ADDR;
  logic [31:0] PData_in;
  logic [31:0] PData_out;
  logic [W-1:0] PIN;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_in #(
    .WIDTH   (W),
    .DB_COUNT(DB),
    .CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .EN       (EN),
    .WE       (WE),
    .ADDR     (ADDR),
    .PData_in (PData_in),
    .PIN      (PIN),
    .PData_out(PData_out),
    .irq      (irq)
  );

  // Reference model: mPin[m] is PIN sampled m+1 edges ago; a level bit moves
  // once its last DB synchronized samples all disagree with it.
  logic [W-1:0] mPin [DB+1];
  logic [W-1:0] mLevel;
  logic [W-1:0] mCap;
  logic [W-1:0] mMask;
  logic [31:0]  mOut;

  always @(posedge clk or posedge rst) begin : model
    logic [W-1:0] allHigh, allLow, newLevel, clrBits, sel;
    if (rst) begin
      for (int i = 0; i <= DB; i++) mPin[i] = '0;
      mLevel = '0;
      mCap   = '0;
      mMask  = '0;
      mOut   = '0;
    end else begin
      allHigh = '1;
      allLow  = '1;
      for (int i = 1; i <= DB; i++) begin
        allHigh &= mPin[i];
        allLow  &= ~mPin[i];
      end
      if (DB_ON) newLevel = (mLevel | allHigh) & ~allLow;
      else       newLevel = mPin[1];
      case (ADDR)
        2'd0:    sel = mLevel;
        2'd1:    sel = mCap;
        2'd2:    sel = mMask;
        default: sel = mPin[1];
      endcase
      clrBits = (EN && WE && ADDR == 2'd1) ? PData_in[W-1:0] : '0;
      if (EN && !WE) mOut = {24'b0, sel};
      if (EN && WE && ADDR == 2'd2) mMask = PData_in[W-1:0];
      mCap   = (mCap & ~clrBits) | (newLevel & ~mLevel);
      mLevel = newLevel;
      for (int i = DB; i > 0; i--) mPin[i] = mPin[i-1];
      mPin[0] = PIN;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic we,
                               input logic [1:0] a, input logic [31:0] d);
    EN       = en;
    WE       = we;
    ADDR     = a;
    PData_in = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    PIN = '1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    repeat (3) tick();
    checks += 2;
    if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_pdata got=%h exp=0", PData_out); end
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    checks++;
    if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_read got=%h exp=0", PData_out); end
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (PData_out !== mOut) begin failures++; $display("[TB] FAIL reset_level_model k=%0d got=%h exp=%h", k, PData_out, mOut); end
      if (k == LAT) begin
        checks++;
        if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL reset_level_early got=%h exp=0", PData_out); end
      end
      if (k == LAT + 1) begin
        checks++;
        if (PData_out !== 32'hFF) begin failures++; $display("[TB] FAIL reset_level_set got=%h exp=ff", PData_out); end
      end
    end
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    checks += 2;
    if (PData_out !== 32'hFF) begin failures++; $display("[TB] FAIL reset_capture got=%h exp=ff", PData_out); end
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq_masked got=%b exp=0", irq); end
  endtask

  task automatic test_glitch();
    logic seen;
    PIN = '0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    repeat (LAT + 4) tick();
    for (int len = 3; len <= 4; len++) begin
      applyStimulus(1'b1, 1'b1, 2'd1, 32'hFF);
      tick();
      applyStimulus(1'b1, 1'b0, 2'd0, 32'h0);
      PIN  = 8'h01;
      seen = 1'b0;
      for (int k = 0; k < DB + LAT + 4; k++) begin
        if (k == len) PIN = '0;
        tick();
        checks++;
        if (PData_out !== mOut) begin failures++; $display("[TB] FAIL glitch_level_model len=%0d got=%h exp=%h", len, PData_out, mOut); end
        if (PData_out[0]) seen = 1'b1;
      end
      applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
      tick();
      checks += 3;
      if (seen !== (len == 4 || !DB_ON)) begin failures++; $display("[TB] FAIL glitch_level_seen len=%0d got=%b exp=%b", len, seen, (len == 4 || !DB_ON)); end
      if (PData_out[0] !== (len == 4 || !DB_ON)) begin failures++; $display("[TB] FAIL glitch_capture len=%0d got=%h", len, PData_out); end
      if (PData_out !== mOut) begin failures++; $display("[TB] FAIL glitch_capture_model got=%h exp=%h", PData_out, mOut); end
    end
  endtask

  task automatic test_irq();
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h01);
    tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("[TB] FAIL irq_set got=%b exp=1", irq); end
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h01);
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear got=%b exp=0", irq); end
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    checks++;
    if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL irq_capture_cleared got=%h exp=0", PData_out); end
  endtask

  task automatic test_clear_race();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    PIN = 8'h01;
    repeat (LAT - 1) tick();
    applyStimulus(1'b1, 1'b1, 2'd1, 32'h01);
    tick();
    checks += 2;
    if (irq !== 1'b1) begin failures++; $display("[TB] FAIL race_irq got=%b exp=1", irq); end
    if (irq !== |(mCap & mMask)) begin failures++; $display("[TB] FAIL race_irq_model got=%b exp=%b", irq, |(mCap & mMask)); end
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    checks++;
    if (PData_out !== 32'h01) begin failures++; $display("[TB] FAIL race_capture got=%h exp=01", PData_out); end
    PIN = '0;
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hFF);
    tick();
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    repeat (LAT + 2) tick();
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h0);
    tick();
    checks++;
    if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL falling_not_captured got=%h exp=0", PData_out); end
  endtask

  task automatic test_readonly();
    applyStimulus(1'b1, 1'b1, 2'd0, 32'hAA);
    tick();
    applyStimulus(1'b1, 1'b1, 2'd3, 32'hAA);
    tick();
    for (int a = 0; a < 4; a += 3) begin
      applyStimulus(1'b1, 1'b0, 2'(a), 32'h0);
      tick();
      checks++;
      if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL readonly_addr%0d got=%h exp=0", a, PData_out); end
    end
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h5A);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h0);
    tick();
    checks++;
    if (PData_out !== 32'h5A) begin failures++; $display("[TB] FAIL mask_read got=%h exp=5a", PData_out); end
    applyStimulus(1'b0, 1'b1, 2'd2, 32'hFF);
    tick();
    checks++;
    if (PData_out !== 32'h5A) begin failures++; $display("[TB] FAIL pdata_hold got=%h exp=5a", PData_out); end
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h0);
    tick();
    checks += 2;
    if (PData_out !== 32'h5A) begin failures++; $display("[TB] FAIL we_without_en got=%h exp=5a", PData_out); end
    if (irq !== 1'b0) begin failures++; $display("[TB] FAIL readonly_irq got=%b exp=0", irq); end
  endtask

  task automatic test_latency();
    applyStimulus(1'b1, 1'b1, 2'd2, 32'h08);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd3, 32'h0);
    PIN = 8'h08;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks += 2;
      if (irq !== (k >= LAT)) begin failures++; $display("[TB] FAIL latency_irq k=%0d got=%b exp=%b", k, irq, (k >= LAT)); end
      if (PData_out !== mOut) begin failures++; $display("[TB] FAIL latency_raw_model k=%0d got=%h exp=%h", k, PData_out, mOut); end
      if (k == 2 || k == 3) begin
        checks++;
        if (PData_out[3] !== (k == 3)) begin failures++; $display("[TB] FAIL latency_raw k=%0d got=%b exp=%b", k, PData_out[3], (k == 3)); end
      end
    end
    PIN = '0;
    applyStimulus(1'b1, 1'b1, 2'd1, 32'hFF);
    tick();
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 9) == 0) PIN = W'($urandom);
      op = 3'($urandom_range(0, 7));
      applyStimulus(op != 0, op == 1, 2'($urandom_range(0, 3)), $urandom);
      tick();
      checks += 2;
      if (PData_out !== mOut) begin failures++; $display("[TB] FAIL random_pdata n=%0d got=%h exp=%h", n, PData_out, mOut); end
      if (irq !== |(mCap & mMask)) begin failures++; $display("[TB] FAIL random_irq n=%0d got=%b exp=%b", n, irq, |(mCap & mMask)); end
    end
  endtask

  task automatic test_reset_mid();
    PIN = '0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    repeat (LAT + 4) tick();
    PIN = '1;
    repeat (LAT - 1) tick();
    rst = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      checks++;
      if (PData_out !== mOut) begin failures++; $display("[TB] FAIL midreset_model k=%0d got=%h exp=%h", k, PData_out, mOut); end
      if (k == LAT) begin
        checks++;
        if (PData_out !== 32'h0) begin failures++; $display("[TB] FAIL midreset_early got=%h exp=0", PData_out); end
      end
      if (k == LAT + 1) begin
        checks++;
        if (PData_out !== 32'hFF) begin failures++; $display("[TB] FAIL midreset_level got=%h exp=ff", PData_out); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    PIN = '0;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge clk);
    test_reset();
    test_glitch();
    test_irq();
    test_clear_race();
    test_readonly();
    test_latency();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_in.md
# pio_in

Parallel input port: the read-side counterpart to the CPU-written GPIO/LED output port. It samples external switches/buttons through a two-flop synchronizer and an optional per-bit debounce filter. It captures rising edges in sticky, write-1-to-clear flags and raises a maskable interrupt. The CPU reaches it through a small register map on the same `EN`/`PData_in` bus style used by the output port.

## Interface
- `WIDTH`, 8: number of input pins, 1..32.
- `DB_COUNT`, 50000: consecutive stable cycles required before the debounced level changes; must be ≥1.
- `CNT_W`, 16: debounce counter width; must satisfy `2^CNT_W > DB_COUNT`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `EN` in 1: bus select for this port.
- `WE` in 1: write strobe, qualified by `EN`.
- `ADDR` in 2: register select.
- `PData_in` in 32: write data.
- `PIN` in WIDTH: raw, asynchronous external inputs.
- `PData_out` out 32: registered read data.
- `irq` out 1: interrupt request, level.

## Operation
- Register map; bits above WIDTH read 0.
  - ADDR 0, LEVEL: debounced level, read-only.
  - ADDR 1, CAPTURE: sticky rising-edge flags; writing 1 clears a bit.
  - ADDR 2, MASK: irq enable, read/write.
  - ADDR 3, RAW: synchronizer output, read-only.
- Writes to read-only addresses are ignored.
- Synchronizer:
  - `sync1 <= PIN`; `sync2 <= sync1`.
- Debounce, per bit, with macro enabled:
  - If `sync2 == level`: `cnt <= 0`.
  - Else if `cnt == DB_COUNT-1`: `level <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than DB_COUNT cycles returns sync2 to level, which zeroes `cnt`, so no change occurs.
- Capture:
  - `capture <= (capture & ~clr) | rise`.
  - `rise = level_next & ~level`.
  - `clr = PData_in[WIDTH-1:0]` when a write targets ADDR 1, else 0.
  - A new edge in the same cycle as a clear wins: the bit stays set.
- Falling edges are not captured.
- `irq = |(capture & mask)`: combinational from registers only.
- Read: on each edge with `EN && !WE`, `PData_out <= selected register`, zero-extended. Otherwise it holds. Reads never clear state.
- `WE` without `EN` has no effect.

## Timing
- Reset values: `sync1`, `sync2`, `level`, all `cnt`, `capture`, `mask`, `PData_out` and `irq` are all 0.
- Reset mid-debounce discards the count. A pin held high through reset requires a full debounce period afterwards; it then produces a capture.
- PIN to RAW: visible at edge 2 after the first sampling edge.
- PIN to LEVEL: updates at edge DB_COUNT+2 when the input is held stable.
- Capture bit sets on the same edge as the LEVEL rise. `irq` asserts in that same cycle if the bit is masked in.
- Read latency: 1 cycle. `PData_out` is valid after the edge that sampled `EN && !WE`.
- Write latency: MASK or CAPTURE-clear takes effect at the write edge. `irq` drops the same cycle.

## Configuration
- `PIO_IN_DEBOUNCE_EN` defined:
  - Per-bit debounce counters are present as described.
- `PIO_IN_DEBOUNCE_EN` not defined:
  - No counters; `level <= sync2` every cycle; PIN-to-LEVEL latency is 3 edges.
  - `DB_COUNT` and `CNT_W` are ignored.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - register address constants `PIO_IN_LEVEL=0`, `PIO_IN_CAPTURE=1`, `PIO_IN_MASK=2`, `PIO_IN_RAW=3`;
  - default `DB_COUNT`.
- One sub-module, `pio_in_debounce`, covers a single bit: counter plus level flop. It is instantiated WIDTH times in a generate loop and replaced by a plain flop when the macro is absent.

## Test plan
Use `DB_COUNT=4` and the macro enabled unless noted.
- Reset with `PIN=8'hFF` held → all outputs 0 during reset. After release, LEVEL=8'hFF at edge 6, CAPTURE=8'hFF, and `irq` stays 0 while `mask=0`.
- `PIN[0]` pulses high for 3 cycles → LEVEL and CAPTURE bit 0 stay 0. A 4-cycle pulse sets LEVEL[0] at edge 6 and CAPTURE[0]=1.
- MASK=8'h01 and CAPTURE[0] set → `irq`=1. A write of 8'h01 to ADDR 1 → `irq`=0 in the same cycle and CAPTURE reads 0.
- Write-clear to ADDR 1 on the same edge a new rise on bit 0 occurs → CAPTURE[0] remains 1.
- Write 8'hAA to ADDR 0 and to ADDR 3 → no change. Read ADDR 2 after MASK=8'h5A → `PData_out=32'h0000005A` one cycle later.
- Macro undefined: a `PIN[3]` rise → RAW[3] at edge 2, LEVEL[3] and CAPTURE[3] at edge 3.
